// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Shares the register file's single write port between two writeback sources:
//   requester 0 - single-cycle execute pipeline
//   requester 1 - long-latency unit (load / mul / div)
//
// Arbitration is round-robin with a valid/ready handshake. The write port
// (write_enable / write_index / write_data) is driven from registers, so a
// handshake in cycle t appears on the write port during cycle t+1.
//
// Optional feature macro: WRITEBACK_SCOREBOARD_EN
//   defined   - a pending bit per architectural register is kept. Decode
//               receives RAW (rs1/rs2) and WAW (rd) stall flags.
//   undefined - no pending storage. All *_pending flags are tied to 0.
//
// Parameters
//   WIDTH  data width, matches the register file
//   DEPTH  register index width (2**DEPTH registers)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/index/data         requester 0 result (in)
//   req0_ready                    requester 0 granted this cycle (out, comb)
//   req1_valid/index/data         requester 1 result (in)
//   req1_ready                    requester 1 granted this cycle (out, comb)
//   write_enable/index/data       register file write port (out, registered)
//   issue_valid, issue_index      decode issues an instruction writing issue_index
//   read_index_1, read_index_2    decode source registers
//   rs1_pending, rs2_pending      source register awaits writeback (out, comb)
//   rd_pending                    issue_index awaits writeback (out, comb)
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [DEPTH-1:0] req0_index,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DEPTH-1:0] req1_index,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             write_enable,
  output logic [DEPTH-1:0] write_index,
  output logic [WIDTH-1:0] write_data,
  input  logic             issue_valid,
  input  logic [DEPTH-1:0] issue_index,
  input  logic [DEPTH-1:0] read_index_1,
  input  logic [DEPTH-1:0] read_index_2,
  output logic             rs1_pending,
  output logic             rs2_pending,
  output logic             rd_pending
);

  // Priority pointer: 0 -> requester 0 wins a tie, 1 -> requester 1 wins.
  logic             ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [DEPTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             grant0, grant1, any_grant;
  logic [DEPTH-1:0] win_index;
  logic [WIDTH-1:0] win_data;

  // Grants are masked by rst_n so no handshake can complete while the
  // asynchronous reset is held; requesters re-present after release.
  assign grant0    = rst_n && req0_valid && (!req1_valid || !ptr_q);
  assign grant1    = rst_n && req1_valid && (!req0_valid ||  ptr_q);
  assign any_grant = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign win_index = grant1 ? req1_index : req0_index;
  assign win_data  = grant1 ? req1_data  : req0_data;

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    idx_d  = idx_q;
    data_d = data_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end
    if (any_grant) begin
      // A write to r0 completes the handshake but never reaches the file.
      we_d   = (win_index != '0);
      idx_d  = win_index;
      data_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 1'b0;
      we_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign write_enable = we_q;
  assign write_index  = idx_q;
  assign write_data   = data_q;

`ifdef WRITEBACK_SCOREBOARD_EN
  localparam int NREG = 1 << DEPTH;

  logic [NREG-1:0] pending_q, pending_d;

  // Clear happens on the same edge the register file commits (write_enable
  // high). A set of the same index on that edge is applied afterwards, so
  // set wins.
  always_comb begin
    pending_d = pending_q;
    if (we_q) begin
      pending_d[idx_q] = 1'b0;
    end
    if (issue_valid && (issue_index != '0)) begin
      pending_d[issue_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // r0 is never set, the explicit guard just makes the zero-read obvious.
  assign rs1_pending = (read_index_1 != '0) && pending_q[read_index_1];
  assign rs2_pending = (read_index_2 != '0) && pending_q[read_index_2];
  assign rd_pending  = (issue_index  != '0) && pending_q[issue_index];
`else
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{issue_valid, issue_index, read_index_1, read_index_2};

  assign rs1_pending = 1'b0;
  assign rs2_pending = 1'b0;
  assign rd_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed-vector bench for writeback_arbiter. Inputs change 1 time unit after
// a rising edge; outputs are sampled on the falling edge. Expected values are
// hand-computed constants in each scenario task.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;

`ifdef WRITEBACK_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [DEPTH-1:0] req0_index;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [DEPTH-1:0] req1_index;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             write_enable;
  logic [DEPTH-1:0] write_index;
  logic [WIDTH-1:0] write_data;
  logic             issue_valid;
  logic [DEPTH-1:0] issue_index;
  logic [DEPTH-1:0] read_index_1;
  logic [DEPTH-1:0] read_index_2;
  logic             rs1_pending;
  logic             rs2_pending;
  logic             rd_pending;

  int vectors;
  int miscompares;

  writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_index   (req0_index),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_index   (req1_index),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data),
    .issue_valid  (issue_valid),
    .issue_index  (issue_index),
    .read_index_1 (read_index_1),
    .read_index_2 (read_index_2),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending),
    .rd_pending   (rd_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decode must never issue onto a register that is still pending.
  always @(negedge clk) begin
    if (rst_n && issue_valid && rd_pending) begin
      miscompares++;
      $display("FAIL protocol_waw: issue_valid with rd_pending=1 index=%0d", issue_index);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_index = 5'd3; req0_data = 32'hAAAA_0001;
    req1_valid = 1'b1; req1_index = 5'd4; req1_data = 32'hBBBB_0001;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_grant: ready0/1=%b%b expected 10", req0_ready, req1_ready);
    end
    next_cycle();
    req0_data = 32'hAAAA_0002;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || write_enable !== 1'b1 || write_index !== 5'd3) begin
      miscompares++;
      $display("FAIL reset_pre_write: ready1=%b we=%b idx=%0d expected 1 1 3",
               req1_ready, write_enable, write_index);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || write_enable !== 1'b0 ||
        write_index !== 5'd0 || write_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: r0=%b r1=%b we=%b idx=%0d data=%h expected all 0",
               req0_ready, req1_ready, write_enable, write_index, write_data);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ptr_cleared: ready0/1=%b%b expected 10", req0_ready, req1_ready);
    end
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || write_index !== 5'd3 || write_data !== 32'hAAAA_0002) begin
      miscompares++;
      $display("FAIL reset_post_write: we=%b idx=%0d data=%h expected 1 3 aaaa0002",
               write_enable, write_index, write_data);
    end
    $display("reset: in-flight write dropped, req0 re-granted after release");
    next_cycle();
  endtask

  task automatic test_solo();
    req1_valid = 1'b1; req1_index = 5'd7; req1_data = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL solo_ready: ready0/1=%b%b expected 01", req0_ready, req1_ready);
    end
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || write_index !== 5'd7 || write_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL solo_write: we=%b idx=%0d data=%h expected 1 7 deadbeef",
               write_enable, write_index, write_data);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b0 || write_index !== 5'd7 || write_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL solo_idle: we=%b idx=%0d data=%h expected 0 7 deadbeef",
               write_enable, write_index, write_data);
    end
    $display("solo: req1 r7 <= deadbeef");
    next_cycle();
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] exp_data [4];
    logic [DEPTH-1:0] exp_idx  [4];
    exp_data[0] = 32'h100; exp_idx[0] = 5'd1;
    exp_data[1] = 32'h200; exp_idx[1] = 5'd2;
    exp_data[2] = 32'h101; exp_idx[2] = 5'd1;
    exp_data[3] = 32'h201; exp_idx[3] = 5'd2;
    req0_valid = 1'b1; req0_index = 5'd1; req0_data = 32'h100;
    req1_valid = 1'b1; req1_index = 5'd2; req1_data = 32'h200;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) begin
        miscompares++;
        $display("FAIL contention_grant%0d: ready0/1=%b%b expected winner %0d",
                 c, req0_ready, req1_ready, c % 2);
      end
      if (c > 0) begin
        vectors++;
        if (write_enable !== 1'b1 || write_index !== exp_idx[c-1] ||
            write_data !== exp_data[c-1]) begin
          miscompares++;
          $display("FAIL contention_write%0d: we=%b idx=%0d data=%h expected 1 %0d %h",
                   c - 1, write_enable, write_index, write_data, exp_idx[c-1], exp_data[c-1]);
        end
      end
      $display("contention: cycle %0d grant to req%0d", c, c % 2);
      next_cycle();
      // Only the winner presents fresh data; the loser holds.
      if (c % 2 == 0) req0_data = req0_data + 32'd1;
      else            req1_data = req1_data + 32'd1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || write_index !== exp_idx[3] || write_data !== exp_data[3]) begin
      miscompares++;
      $display("FAIL contention_write3: we=%b idx=%0d data=%h expected 1 2 00000201",
               write_enable, write_index, write_data);
    end
    next_cycle();
  endtask

  task automatic test_index0();
    req0_valid = 1'b1; req0_index = 5'd0; req0_data = 32'h1234;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL index0_ready: ready0/1=%b%b expected 10", req0_ready, req1_ready);
    end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL index0_we: we=%b expected 0", write_enable);
    end
    $display("index0: req0 r0 <= 1234 suppressed");
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        req0_valid = 1'b1;
        req0_index = 5'(10 + c);
        req0_data  = 32'hC000_0000 + 32'(c);
      end else begin
        req0_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 3) begin
        vectors++;
        if (req0_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready%0d: ready0=%b expected 1", c, req0_ready);
        end
      end
      if (c > 0) begin
        vectors++;
        if (write_enable !== 1'b1 || write_index !== 5'(9 + c) ||
            write_data !== 32'hC000_0000 + 32'(c - 1)) begin
          miscompares++;
          $display("FAIL b2b_write%0d: we=%b idx=%0d data=%h expected 1 %0d %h",
                   c - 1, write_enable, write_index, write_data, 9 + c,
                   32'hC000_0000 + 32'(c - 1));
        end
      end
      $display("back_to_back: cycle %0d", c);
      next_cycle();
    end
  endtask

  task automatic test_scoreboard();
    // Issue r5.
    issue_valid = 1'b1; issue_index = 5'd5; read_index_1 = 5'd5; read_index_2 = 5'd5;
    @(negedge clk);
    vectors++;
    if (rs1_pending !== 1'b0 || rd_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_before_set: rs1=%b rd=%b expected 0 0", rs1_pending, rd_pending);
    end
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rs1_pending !== SB || rs2_pending !== SB || rd_pending !== SB) begin
      miscompares++;
      $display("FAIL sb_set: rs1=%b rs2=%b rd=%b expected %b", rs1_pending, rs2_pending,
               rd_pending, SB);
    end
    read_index_2 = 5'd0;
    #1;
    vectors++;
    if (rs2_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_r0: rs2=%b expected 0", rs2_pending);
    end
    // req1 writes r5.
    next_cycle();
    req1_valid = 1'b1; req1_index = 5'd5; req1_data = 32'h55;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || rs1_pending !== SB) begin
      miscompares++;
      $display("FAIL sb_grant: ready1=%b rs1=%b expected 1 %b", req1_ready, rs1_pending, SB);
    end
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || write_index !== 5'd5 || rs1_pending !== SB) begin
      miscompares++;
      $display("FAIL sb_commit: we=%b idx=%0d rs1=%b expected 1 5 %b",
               write_enable, write_index, rs1_pending, SB);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (rs1_pending !== 1'b0 || write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_cleared: rs1=%b we=%b expected 0 0", rs1_pending, write_enable);
    end
    // Write r5 again and issue r5 on the clearing edge: set must win.
    next_cycle();
    req0_valid = 1'b1; req0_index = 5'd5; req0_data = 32'h66;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_grant2: ready0=%b expected 1", req0_ready);
    end
    next_cycle();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_index = 5'd5;
    @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || write_data !== 32'h66 || rd_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_commit2: we=%b data=%h rd=%b expected 1 00000066 0",
               write_enable, write_data, rd_pending);
    end
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rs1_pending !== SB || rd_pending !== SB) begin
      miscompares++;
      $display("FAIL sb_set_wins: rs1=%b rd=%b expected %b", rs1_pending, rd_pending, SB);
    end
    $display("scoreboard: r5 issue/writeback sequence, scoreboard=%b", SB);
    next_cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req0_valid  = 1'b0; req0_index = '0; req0_data = '0;
    req1_valid  = 1'b0; req1_index = '0; req1_data = '0;
    issue_valid = 1'b0; issue_index = '0;
    read_index_1 = '0;  read_index_2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    test_reset();
    test_solo();
    test_contention();
    test_index0();
    test_back_to_back();
    test_scoreboard();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
